// File: rtl/seg_scan_if.sv
// Producer-side bus of the digit scanner: shadow load/enable inputs and the
// decoder/anode drive outputs.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic [3:0]                digit;
  logic                      update;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output en, load, bcd_in,
    input  digit, update, an, frame_done
  );

  modport slave (
    input  en, load, bcd_in,
    output digit, update, an, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes NUM_DIGITS BCD digits onto one shared seven-segment decoder,
// with a blanking guard after each decoder update to hide its latency.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL        = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DW      = 4 * NUM_DIGITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;
  localparam logic [1:0] SHOW  = 2'd3;

  logic [1:0]            state, state_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DW-1:0]         shadow, shadow_n;
  logic [DW-1:0]         working, work_n;
  logic [3:0]            digit_q, digit_n;
  logic                  update_q;
  logic [NUM_DIGITS-1:0] an_q, an_n;
  logic                  frame_done_q;

  // Bypass: a load on the frame-start cycle reaches working directly.
  assign shadow_n = bus.load ? bus.bcd_in : shadow;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    work_n  = working;
    if (!bus.en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = LOAD;
          idx_n   = '0;
          cnt_n   = '0;
          work_n  = shadow_n;
        end
        LOAD: begin
          state_n = BLANK;
          cnt_n   = '0;
        end
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == CNT_W'(DWELL - 1)) begin
            state_n = LOAD;
            cnt_n   = '0;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
              idx_n  = '0;
              work_n = shadow_n;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with state.
  always_comb begin
    digit_n = work_n[{idx_n, 2'b00} +: 4];
    an_n    = '0;
    if (state_n == SHOW && digit_n <= 4'd9) an_n[idx_n] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      shadow       <= '0;
      working      <= '0;
      digit_q      <= '0;
      update_q     <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      shadow       <= shadow_n;
      working      <= work_n;
      update_q     <= (state_n == LOAD);
      an_q         <= an_n;
      frame_done_q <= (state_n == SHOW) && (cnt_n == CNT_W'(DWELL - 1)) &&
                      (idx_n == IDX_W'(NUM_DIGITS - 1));
      if (state_n == LOAD) digit_q <= digit_n;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.update     = update_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: vector table from reset, directed corner sequences
// and randomized traffic against a frame-position model.
module tb_seg_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned DW    = 4;
  localparam int unsigned BL    = 1;
  localparam int unsigned SLOT  = 1 + BL + DW;
  localparam int unsigned FRAME = ND * SLOT;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();
  seg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  // Model: frame position counter, display derived arithmetically from it.
  logic        m_run;
  int unsigned m_pos;
  logic [15:0] m_shadow, m_work;
  logic [3:0]  m_digit, m_an;
  logic        m_update, m_fd;

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] bcd;
    logic        exp_update;
    logic [3:0]  exp_digit;
    logic [3:0]  exp_an;
    logic        exp_fd;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_shadow = '0; m_work = '0;
    m_digit = '0; m_an = '0; m_update = 1'b0; m_fd = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [15:0] b);
    logic [15:0] sh;
    logic [3:0]  dv;
    int unsigned slot, ph;
    sh = l ? b : m_shadow;
    if (!e) m_run = 1'b0;
    else if (!m_run) begin
      m_run = 1'b1; m_pos = 0; m_work = sh;
    end else begin
      m_pos++;
      if (m_pos == FRAME) begin m_pos = 0; m_work = sh; end
    end
    m_shadow = sh;
    m_update = 1'b0; m_an = '0; m_fd = 1'b0;
    if (m_run) begin
      slot = m_pos / SLOT;
      ph   = m_pos % SLOT;
      dv   = m_work[4*slot +: 4];
      if (ph == 0) begin m_update = 1'b1; m_digit = dv; end
      if (ph >= 1 + BL && dv <= 4'd9) m_an = 4'(1 << slot);
      m_fd = (m_pos == FRAME - 1);
    end
  endtask

  task automatic step(input logic e, input logic l, input logic [15:0] b);
    bus.en = e; bus.load = l; bus.bcd_in = b;
    @(posedge clk);
    model_edge(e, l, b);
    #1;
  endtask

  task automatic check_model();
    chk("update", 16'(bus.update), 16'(m_update));
    chk("digit", 16'(bus.digit), 16'(m_digit));
    chk("an", 16'(bus.an), 16'(m_an));
    chk("frame_done", 16'(bus.frame_done), 16'(m_fd));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 16'h0);
      check_model();
    end
  endtask

  task automatic run_to(input int unsigned pos);
    int unsigned guard = 0;
    while (!(m_run && m_pos == pos) && guard < 2 * FRAME) begin
      step(1'b1, 1'b0, 16'h0);
      check_model();
      guard++;
    end
    chk("run_to_timeout", 16'(guard < 2 * FRAME), 16'd1);
  endtask

  initial begin
    int unsigned act_cycles;
    tbl[0] = '{1'b0, 1'b1, 16'h1234, 1'b0, 4'h0, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'h4, 4'b0000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0001, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0001, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0001, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0001, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'h3, 4'b0000, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h3, 4'b0000, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h3, 4'b0010, 1'b0};

    rst_n = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.bcd_in = '0;
    model_reset();
    #2;
    chk("rst_update", 16'(bus.update), 16'd0);
    chk("rst_digit", 16'(bus.digit), 16'd0);
    chk("rst_an", 16'(bus.an), 16'd0);
    chk("rst_frame_done", 16'(bus.frame_done), 16'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].en, tbl[i].load, tbl[i].bcd);
      chk($sformatf("tbl%0d_update", i), 16'(bus.update), 16'(tbl[i].exp_update));
      chk($sformatf("tbl%0d_digit", i), 16'(bus.digit), 16'(tbl[i].exp_digit));
      chk($sformatf("tbl%0d_an", i), 16'(bus.an), 16'(tbl[i].exp_an));
      chk($sformatf("tbl%0d_fd", i), 16'(bus.frame_done), 16'(tbl[i].exp_fd));
    end

    // Load during slot 1: current frame unaffected, next frame shows 5678.
    step(1'b1, 1'b1, 16'h5678); check_model();
    run_to(0);
    chk("newframe_digit", 16'(bus.digit), 16'h8);
    run(FRAME);

    // Load coinciding with frame_done goes straight into working.
    run_to(FRAME - 1);
    chk("fd_before_bypass", 16'(bus.frame_done), 16'd1);
    step(1'b1, 1'b1, 16'h9999); check_model();
    chk("bypass_digit", 16'(bus.digit), 16'h9);
    run(FRAME);

    // Digit > 9 blanks its slot but keeps timing and still strobes update.
    step(1'b0, 1'b1, 16'h12A4); check_model();
    act_cycles = 0;
    for (int unsigned i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b0, 16'h0); check_model();
      if (bus.an != '0) act_cycles++;
      if (i == SLOT) chk("hexslot_digit", 16'(bus.digit), 16'hA);
    end
    chk("hex_active_cycles", 16'(act_cycles), 16'(3 * DW));

    // Disable in the 2nd SHOW cycle of slot 2, then re-enable.
    run_to(2 * SLOT + 1 + BL + 1);
    step(1'b0, 1'b0, 16'h0); check_model();
    chk("dis_an", 16'(bus.an), 16'd0);
    chk("dis_update", 16'(bus.update), 16'd0);
    chk("dis_digit_hold", 16'(bus.digit), 16'h2);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0); check_model();
      chk("dis_fd", 16'(bus.frame_done), 16'd0);
    end
    step(1'b1, 1'b0, 16'h0); check_model();
    chk("reen_update", 16'(bus.update), 16'd1);
    chk("reen_digit", 16'(bus.digit), 16'h4);
    run(FRAME);

    // Asynchronous reset in the middle of a SHOW phase.
    run_to(SLOT + 1 + BL + 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 16'(bus.an), 16'd0);
    chk("arst_update", 16'(bus.update), 16'd0);
    chk("arst_digit", 16'(bus.digit), 16'd0);
    chk("arst_fd", 16'(bus.frame_done), 16'd0);
    model_reset();
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h0); check_model();
    chk("post_rst_digit", 16'(bus.digit), 16'h0);
    run(FRAME);

    // Randomized enable/load traffic.
    for (int unsigned i = 0; i < 1500; i++) begin
      logic e, l;
      logic [15:0] b;
      e = ($urandom_range(0, 99) < 97);
      l = ($urandom_range(0, 99) < 8);
      b = 16'($urandom);
      if ($urandom_range(0, 3) != 0) b = b & 16'h7777;
      step(e, l, b);
      check_model();
      chk("an_onehot", 16'($countones(bus.an) <= 1), 16'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
